// File: rtl/regmst_pkg.sv
// rtl/regmst_pkg.sv - shared types and helpers for the reg_native_if initiator
package regmst_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RSP   = 3'd3,
        FLUSH = 3'd4
    } regmst_state_e;

    // One counter serves both the ack timeout and the soft_rst pulse, so size it for the larger.
    function automatic int cnt_width(input int tmo_cycles, input int srst_cycles);
        int w;
        w = $clog2(tmo_cycles + 1);
        if ($clog2(srst_cycles + 1) > w) w = $clog2(srst_cycles + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/regmst_disp_map.sv
// rtl/regmst_disp_map.sv - single-outstanding reg_native_if initiator with ack timeout and soft_rst flush
module regmst_disp_map
    import regmst_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int SOFT_RST_CYCLES = 2
) (
    input  logic                  regdisp_disp_map_clk,
    input  logic                  regdisp_disp_map_rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  regmst_disp_map__regdisp_disp_map__req_vld,
    output logic [ADDR_WIDTH-1:0] regmst_disp_map__regdisp_disp_map__addr,
    output logic                  regmst_disp_map__regdisp_disp_map__wr_en,
    output logic                  regmst_disp_map__regdisp_disp_map__rd_en,
    output logic [DATA_WIDTH-1:0] regmst_disp_map__regdisp_disp_map__wr_data,
    output logic                  regmst_disp_map__regdisp_disp_map__soft_rst,
    input  logic                  regdisp_disp_map__regmst_disp_map__ack_vld,
    input  logic                  regdisp_disp_map__regmst_disp_map__err,
    input  logic [DATA_WIDTH-1:0] regdisp_disp_map__regmst_disp_map__rd_data
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, SOFT_RST_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

    regmst_state_e          r_state;
    regmst_state_e          w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_out_en;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_wr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;
    logic                   r_timeout;

    logic w_ack;
    logic w_busy;
    logic w_in_req;
    logic w_in_rsp;
    logic w_cmd_fire;
    logic w_ack_take;

    assign w_ack      = regdisp_disp_map__regmst_disp_map__ack_vld;
    assign w_in_req   = (r_state == REQ);
    assign w_busy     = (r_state == REQ) || (r_state == WAIT);
    assign w_in_rsp   = (r_state == RSP);
    assign w_cmd_fire = cmd_vld && cmd_rdy;
    assign w_ack_take = w_busy && w_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = REQ;
                    w_cnt_nxt   = '0;
                end
            end
            REQ: begin
                w_state_nxt = w_ack ? RSP : WAIT;
            end
            WAIT: begin
                // A same-cycle ack beats the timeout.
                if (w_ack) begin
                    w_state_nxt = RSP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST)) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (r_cnt == SRST_LAST) w_state_nxt = RSP;
                else                    w_cnt_nxt   = r_cnt + 1'b1;
            end
            RSP: begin
                if (rsp_rdy) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge regdisp_disp_map_clk or negedge regdisp_disp_map_rst_n) begin
        if (!regdisp_disp_map_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_out_en  <= 1'b0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out_en <= 1'b1;
            if (w_cmd_fire) begin
                r_addr  <= cmd_addr;
                r_wr    <= cmd_wr;
                r_wdata <= cmd_wdata;
            end
            if (w_ack_take) begin
                r_err     <= regdisp_disp_map__regmst_disp_map__err;
                r_rdata   <= r_wr ? '0 : regdisp_disp_map__regmst_disp_map__rd_data;
                r_timeout <= 1'b0;
            end else if ((r_state == WAIT) && (w_state_nxt == FLUSH)) begin
                r_err     <= 1'b1;
                r_rdata   <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

    // r_out_en keeps cmd_rdy low while reset is held and for the first edge after release.
    assign cmd_rdy     = (r_state == IDLE) && r_out_en;
    assign rsp_vld     = w_in_rsp;
    assign rsp_rdata   = w_in_rsp ? r_rdata : '0;
    assign rsp_err     = w_in_rsp && r_err;
    assign rsp_timeout = w_in_rsp && r_timeout;

    assign regmst_disp_map__regdisp_disp_map__req_vld  = w_in_req;
    assign regmst_disp_map__regdisp_disp_map__wr_en    = w_in_req && r_wr;
    assign regmst_disp_map__regdisp_disp_map__rd_en    = w_in_req && !r_wr;
    assign regmst_disp_map__regdisp_disp_map__addr     = w_busy ? r_addr : '0;
    assign regmst_disp_map__regdisp_disp_map__wr_data  = w_busy ? r_wdata : '0;
    assign regmst_disp_map__regdisp_disp_map__soft_rst = (r_state == FLUSH);

endmodule
